tick_timer: RTL and testbench

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer.sv | 124 ++++++++++++
 tb/tb_tick_timer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_timer.sv
// Programmable interval timer counting one of three external tick strobes or raw refclk cycles.
// Define TICK_TIMER_OVERRUN_EN to build the sticky overrun flag; otherwise overrun is tied low.
module tick_timer #(
    parameter int WIDTH = 16
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             uS_Flag,
    input  logic             mS_Flag,
    input  logic             hundredmS_Flag,
    input  logic [1:0]       tb_sel,
    input  logic [WIDTH-1:0] load_val,
    input  logic             periodic,
    input  logic             start,
    input  logic             stop,
    input  logic             ack,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             expire,
    output logic             pending,
    output logic             overrun
);

    typedef enum logic {IDLE, RUN} timerState_t;

    timerState_t      state, stateNext;
    logic [WIDTH-1:0] countReg, countNext;
    logic [WIDTH-1:0] reloadReg, reloadNext;
    logic [1:0]       tbSelReg, tbSelNext;
    logic             periodicReg, periodicNext;
    logic             expireReg, expireNext;
    logic             pendingReg;
    logic             tickSel;

    always_comb begin
        tickSel = 1'b0;
        case (tbSelReg)
            2'd0:    tickSel = uS_Flag;
            2'd1:    tickSel = mS_Flag;
            2'd2:    tickSel = hundredmS_Flag;
            default: tickSel = 1'b1;
        endcase
    end

    // A one-shot expiry leaves count at 0 in RUN for the expire cycle, then drops to IDLE.
    always_comb begin
        stateNext    = state;
        countNext    = countReg;
        reloadNext   = reloadReg;
        tbSelNext    = tbSelReg;
        periodicNext = periodicReg;
        expireNext   = 1'b0;
        if (stop) begin
            stateNext = IDLE;
            countNext = '0;
        end else if (start && (load_val != '0)) begin
            stateNext    = RUN;
            countNext    = load_val;
            reloadNext   = load_val;
            tbSelNext    = tb_sel;
            periodicNext = periodic;
        end else if (state == RUN) begin
            if (countReg == '0) begin
                stateNext = IDLE;
            end else if (tickSel) begin
                if (countReg == WIDTH'(1)) begin
                    expireNext = 1'b1;
                    countNext  = periodicReg ? reloadReg : '0;
                end else begin
                    countNext = countReg - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state       <= IDLE;
            countReg    <= '0;
            reloadReg   <= '0;
            tbSelReg    <= 2'd0;
            periodicReg <= 1'b0;
            expireReg   <= 1'b0;
            pendingReg  <= 1'b0;
        end else begin
            state       <= stateNext;
            countReg    <= countNext;
            reloadReg   <= reloadNext;
            tbSelReg    <= tbSelNext;
            periodicReg <= periodicNext;
            expireReg   <= expireNext;
            if (expireReg) begin
                pendingReg <= 1'b1;
            end else if (ack) begin
                pendingReg <= 1'b0;
            end
        end
    end

`ifdef TICK_TIMER_OVERRUN_EN
    logic overrunReg;

    // An expiry that lands while the previous one is still unacknowledged is an overrun.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            overrunReg <= 1'b0;
        end else if (expireReg && pendingReg && !ack) begin
            overrunReg <= 1'b1;
        end else if (ack) begin
            overrunReg <= 1'b0;
        end
    end

    assign overrun = overrunReg;
`else
    assign overrun = 1'b0;
`endif

    assign busy    = (state == RUN);
    assign count   = countReg;
    assign expire  = expireReg;
    assign pending = pendingReg;

endmodule

// File: tb/tb_tick_timer.sv
// Directed self-checking bench for tick_timer; expected values are hand-derived cycle by cycle.
// Overrun expectations follow TICK_TIMER_OVERRUN_EN.
module tb_tick_timer;

    localparam int WIDTH = 16;

`ifdef TICK_TIMER_OVERRUN_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic             refclk = 1'b0;
    logic             rst_n;
    logic             uS_Flag, mS_Flag, hundredmS_Flag;
    logic [1:0]       tb_sel;
    logic [WIDTH-1:0] load_val;
    logic             periodic, start, stop, ack;
    logic             busy, expire, pending, overrun;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    tick_timer #(.WIDTH(WIDTH)) dut (
        .refclk(refclk), .rst_n(rst_n),
        .uS_Flag(uS_Flag), .mS_Flag(mS_Flag), .hundredmS_Flag(hundredmS_Flag),
        .tb_sel(tb_sel), .load_val(load_val), .periodic(periodic),
        .start(start), .stop(stop), .ack(ack),
        .busy(busy), .count(count), .expire(expire),
        .pending(pending), .overrun(overrun)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    initial begin
        int seen;
        rst_n = 1'b0; uS_Flag = 1'b0; mS_Flag = 1'b0; hundredmS_Flag = 1'b0;
        tb_sel = 2'd0; load_val = '0; periodic = 1'b0;
        start = 1'b0; stop = 1'b0; ack = 1'b0;
        applyStimulus(2);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstCount", 32'(count), 0);
        checkOutput("rstExpire", 32'(expire), 0);
        checkOutput("rstPending", 32'(pending), 0);
        checkOutput("rstOverrun", 32'(overrun), 0);
        rst_n = 1'b1;
        applyStimulus(1);

        // One-shot on refclk, load 5
        tb_sel = 2'd3; load_val = 16'd5; periodic = 1'b0; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("t1Count", 32'(count), 32'(5 - i));
            checkOutput("t1Busy", 32'(busy), 1);
            checkOutput("t1Expire", 32'(expire), 0);
            applyStimulus(1);
        end
        checkOutput("t1ExpBusy", 32'(busy), 1);
        checkOutput("t1ExpPulse", 32'(expire), 1);
        checkOutput("t1ExpCount", 32'(count), 0);
        checkOutput("t1ExpPending", 32'(pending), 0);
        ack = 1'b1;
        applyStimulus(1);
        ack = 1'b0;
        checkOutput("t1IdleBusy", 32'(busy), 0);
        checkOutput("t1IdleExpire", 32'(expire), 0);
        checkOutput("t1IdleCount", 32'(count), 0);
        checkOutput("t1PendingAckSame", 32'(pending), 1);
        ack = 1'b1;
        applyStimulus(1);
        ack = 1'b0;
        checkOutput("t1PendingCleared", 32'(pending), 0);

        // Periodic on mS_Flag every 12 cycles; inputs disturbed mid-run without start
        tb_sel = 2'd1; load_val = 16'd3; periodic = 1'b1; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        for (int c = 1; c <= 110; c++) begin
            checkOutput("t2Expire", 32'(expire), (c > 1 && c % 36 == 1) ? 32'd1 : 32'd0);
            checkOutput("t2Busy", 32'(busy), 1);
            if (c == 13) checkOutput("t2CountDec", 32'(count), 2);
            if (c == 37) checkOutput("t2CountReload", 32'(count), 3);
            if (c == 50) begin
                tb_sel = 2'd3; load_val = 16'd9; periodic = 1'b0;
            end
            mS_Flag = (c % 12 == 0);
            applyStimulus(1);
            mS_Flag = 1'b0;
        end
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("t2StopBusy", 32'(busy), 0);
        checkOutput("t2StopCount", 32'(count), 0);
        seen = 0;
        mS_Flag = 1'b1; uS_Flag = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (expire) seen++;
            applyStimulus(1);
        end
        mS_Flag = 1'b0; uS_Flag = 1'b0;
        checkOutput("t2NoExpireAfterStop", 32'(seen), 0);
        ack = 1'b1;
        applyStimulus(1);
        ack = 1'b0;

        // Zero load ignored; restart mid-interval
        tb_sel = 2'd3; load_val = '0; periodic = 1'b0; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("t3ZeroBusy", 32'(busy), 0);
        applyStimulus(1);
        checkOutput("t3ZeroBusy2", 32'(busy), 0);
        checkOutput("t3ZeroExpire", 32'(expire), 0);
        load_val = 16'd6; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("t3Count6", 32'(count), 6);
        applyStimulus(1);
        load_val = '0; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("t3ZeroInRun", 32'(count), 4);
        checkOutput("t3ZeroInRunBusy", 32'(busy), 1);
        applyStimulus(2);
        checkOutput("t3Count2", 32'(count), 2);
        load_val = 16'd4; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("t3Restart", 32'(count), 32'(4 - i));
            checkOutput("t3RestartExpire", 32'(expire), 0);
            applyStimulus(1);
        end
        checkOutput("t3Expire", 32'(expire), 1);
        applyStimulus(1);
        ack = 1'b1;
        applyStimulus(1);
        ack = 1'b0;

        // Stop collides with terminal tick
        load_val = 16'd3; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(2);
        checkOutput("t4CountAt1", 32'(count), 1);
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("t4Expire", 32'(expire), 0);
        checkOutput("t4Count", 32'(count), 0);
        checkOutput("t4Busy", 32'(busy), 0);
        applyStimulus(1);
        checkOutput("t4ExpireLate", 32'(expire), 0);
        checkOutput("t4Pending", 32'(pending), 0);

        // Back-to-back periodic expiries without ack
        load_val = 16'd1; periodic = 1'b1; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("t5Count", 32'(count), 1);
        checkOutput("t5Pending0", 32'(pending), 0);
        applyStimulus(1);
        checkOutput("t5Expire1", 32'(expire), 1);
        checkOutput("t5PendingLag", 32'(pending), 0);
        applyStimulus(1);
        checkOutput("t5Expire2", 32'(expire), 1);
        checkOutput("t5Pending1", 32'(pending), 1);
        checkOutput("t5OverrunEarly", 32'(overrun), 0);
        applyStimulus(1);
        checkOutput("t5Overrun", 32'(overrun), 32'(OVR_EXP));
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("t5StopExpire", 32'(expire), 0);
        checkOutput("t5StopPending", 32'(pending), 1);
        checkOutput("t5StopOverrun", 32'(overrun), 32'(OVR_EXP));
        ack = 1'b1;
        applyStimulus(1);
        ack = 1'b0;
        checkOutput("t5AckPending", 32'(pending), 0);
        checkOutput("t5AckOverrun", 32'(overrun), 0);

        // Reset mid-interval beats start/ack/ticks
        load_val = 16'd10; periodic = 1'b0; start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(3);
        checkOutput("t6Count7", 32'(count), 7);
        rst_n = 1'b0; start = 1'b1; load_val = 16'd9; ack = 1'b1; uS_Flag = 1'b1;
        applyStimulus(1);
        rst_n = 1'b1; start = 1'b0; ack = 1'b0;
        checkOutput("t6Busy", 32'(busy), 0);
        checkOutput("t6Count", 32'(count), 0);
        checkOutput("t6Expire", 32'(expire), 0);
        checkOutput("t6Pending", 32'(pending), 0);
        checkOutput("t6Overrun", 32'(overrun), 0);
        applyStimulus(5);
        uS_Flag = 1'b0;
        checkOutput("t6StayIdle", 32'(busy), 0);
        checkOutput("t6StayCount", 32'(count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
